// File: rtl/uart_frame_tx.sv
// Frame serializer: shifts a latched 12-bit frame out MSB first, one bit per CLKS_PER_BIT cycles.
// Optional frame parity check is enabled by defining UART_FRAME_TX_PARITY_CHECK_EN.
module uart_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FRAME_W      = 12,
  parameter logic        IDLE_LEVEL   = 1'b1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [FRAME_W-1:0] FRAME_IN,
  input  logic               FRAME_VALID,
  output logic               FRAME_READY,
  output logic               TX,
  output logic               BUSY,
  output logic               DONE,
  output logic               PARITY_ERR
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = $clog2(FRAME_W);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_W - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               accept_s;
  logic               baud_term_s;
  logic               last_bit_s;

  assign accept_s    = FRAME_VALID && ready_q;
  assign baud_term_s = (baud_q == BAUD_LAST);
  assign last_bit_s  = (bit_q == BIT_LAST);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (baud_term_s && last_bit_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shift register and counters; the bit counter is cleared at the last bit so it never leaves 0..FRAME_W-1
  always_comb begin
    shift_d = shift_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          shift_d = FRAME_IN;
          baud_d  = {BAUD_W{1'b0}};
          bit_d   = {BIT_W{1'b0}};
        end else begin
          shift_d = shift_q;
        end
      end
      ST_SHIFT: begin
        if (baud_term_s) begin
          baud_d  = {BAUD_W{1'b0}};
          shift_d = {shift_q[FRAME_W-2:0], IDLE_LEVEL};
          if (last_bit_s) begin
            bit_d = {BIT_W{1'b0}};
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        shift_d = shift_q;
      end
    endcase
  end

  // Output logic, computed from next-state values so the registered outputs line up with the state
  always_comb begin
    tx_d    = IDLE_LEVEL;
    busy_d  = 1'b0;
    ready_d = 1'b1;
    done_d  = 1'b0;
    if (state_d == ST_SHIFT) begin
      tx_d    = shift_d[FRAME_W-1];
      busy_d  = 1'b1;
      ready_d = 1'b0;
    end else begin
      tx_d    = IDLE_LEVEL;
      busy_d  = 1'b0;
      ready_d = 1'b1;
    end
    if ((state_q == ST_SHIFT) && baud_term_s && last_bit_s) begin
      done_d = 1'b1;
    end else begin
      done_d = 1'b0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shift_q <= {FRAME_W{1'b0}};
      baud_q  <= {BAUD_W{1'b0}};
      bit_q   <= {BIT_W{1'b0}};
      tx_q    <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign TX          = tx_q;
  assign BUSY        = busy_q;
  assign FRAME_READY = ready_q;
  assign DONE        = done_q;

`ifdef UART_FRAME_TX_PARITY_CHECK_EN
  logic parity_err_q, parity_err_d;

  function automatic logic even_parity8(input logic [7:0] data);
    return ^data;
  endfunction

  // Parity mismatch is captured on accept and held until the next accept
  always_comb begin
    if (accept_s) begin
      parity_err_d = (even_parity8(FRAME_IN[10:3]) != FRAME_IN[2]);
    end else begin
      parity_err_d = parity_err_q;
    end
  end

  // Parity flag register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign PARITY_ERR = parity_err_q;
`else
  assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: two instances (4 and 1 clocks per bit) checked
// cycle by cycle against a frame-level reference model.
module tb_uart_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] frame_in;
  logic        valid_a, valid_b;
  logic        ready_a, tx_a, busy_a, done_a, perr_a;
  logic        ready_b, tx_b, busy_b, done_b, perr_b;

  int checks   = 0;
  int failures = 0;
  logic exp_perr [2];

  always #5 clk = ~clk;

  uart_frame_tx #(.CLKS_PER_BIT(4)) dut_a (
    .CLK(clk), .RST_N(rst_n), .FRAME_IN(frame_in), .FRAME_VALID(valid_a),
    .FRAME_READY(ready_a), .TX(tx_a), .BUSY(busy_a), .DONE(done_a), .PARITY_ERR(perr_a)
  );

  uart_frame_tx #(.CLKS_PER_BIT(1)) dut_b (
    .CLK(clk), .RST_N(rst_n), .FRAME_IN(frame_in), .FRAME_VALID(valid_b),
    .FRAME_READY(ready_b), .TX(tx_b), .BUSY(busy_b), .DONE(done_b), .PARITY_ERR(perr_b)
  );

  function automatic int cpb_of(input int sel);
    return (sel == 0) ? 4 : 1;
  endfunction

  // Expected parity flag for an accepted frame
  function automatic logic model_perr(input logic [11:0] f);
`ifdef UART_FRAME_TX_PARITY_CHECK_EN
    logic [7:0] data;
    data = f[10:3];
    return ((^data) != f[2]);
`else
    return (f[0] & 1'b0);
`endif
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int sel, input logic e_ready,
                          input logic e_tx, input logic e_busy, input logic e_done);
    if (sel == 0) begin
      chk({tag, ".ready_a"}, ready_a, e_ready);
      chk({tag, ".tx_a"},    tx_a,    e_tx);
      chk({tag, ".busy_a"},  busy_a,  e_busy);
      chk({tag, ".done_a"},  done_a,  e_done);
      chk({tag, ".perr_a"},  perr_a,  exp_perr[0]);
    end else begin
      chk({tag, ".ready_b"}, ready_b, e_ready);
      chk({tag, ".tx_b"},    tx_b,    e_tx);
      chk({tag, ".busy_b"},  busy_b,  e_busy);
      chk({tag, ".done_b"},  done_b,  e_done);
      chk({tag, ".perr_b"},  perr_b,  exp_perr[1]);
    end
  endtask

  task automatic set_valid(input int sel, input logic v);
    if (sel == 0) valid_a = v;
    else          valid_b = v;
  endtask

  // Present a frame at an idle negedge; returns at the negedge after the accept edge with valid still high
  task automatic offer(input string tag, input int sel, input logic [11:0] f);
    chk_outs({tag, ".offer"}, sel, 1'b1, 1'b1, 1'b0, (sel == 0) ? done_a : done_b);
    frame_in = f;
    set_valid(sel, 1'b1);
    @(negedge clk);
    exp_perr[sel] = model_perr(f);
  endtask

  // Check every cycle of an accepted frame; returns at the DONE negedge.
  // mode 0: quiet inputs, 1: random FRAME_IN noise, 2: FRAME_VALID with 12'hFFF during bit 5
  task automatic body(input string tag, input int sel, input logic [11:0] f, input int mode);
    int cpb;
    int idx;
    cpb = cpb_of(sel);
    for (int k = 0; k < 12 * cpb; k++) begin
      idx = 11 - (k / cpb);
      chk($sformatf("%s.bit%0d", tag, idx), sel == 0 ? tx_a : tx_b, f[idx]);
      chk({tag, ".busy"},  sel == 0 ? busy_a  : busy_b,  1'b1);
      chk({tag, ".ready"}, sel == 0 ? ready_a : ready_b, 1'b0);
      chk({tag, ".done"},  sel == 0 ? done_a  : done_b,  1'b0);
      chk({tag, ".perr"},  sel == 0 ? perr_a  : perr_b,  exp_perr[sel]);
      if (mode == 1) begin
        frame_in = 12'($urandom);
      end else if (mode == 2 && k == 5 * cpb) begin
        frame_in = 12'hFFF;
        set_valid(sel, 1'b1);
      end else if (mode == 2 && k == 6 * cpb) begin
        set_valid(sel, 1'b0);
      end
      @(negedge clk);
    end
    chk_outs({tag, ".end"}, sel, 1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic idle_cycle(input string tag, input int sel);
    @(negedge clk);
    chk_outs(tag, sel, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [11:0] f;
    int sel;
    int mode;
    int gap;

    rst_n       = 1'b0;
    valid_a     = 1'b0;
    valid_b     = 1'b0;
    frame_in    = 12'h000;
    exp_perr[0] = 1'b0;
    exp_perr[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk_outs("reset", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_outs("reset", 1, 1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_outs("post_reset", 0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Single frame, 1-cycle valid pulse, FRAME_IN noise while shifting
    offer("t1", 0, 12'h920);
    valid_a = 1'b0;
    body("t1", 0, 12'h920, 1);
    idle_cycle("t1.after", 0);

    // Back-to-back with valid held: second frame taken on the DONE cycle
    offer("t2a", 0, 12'h920);
    frame_in = 12'hC0C;
    body("t2a", 0, 12'h920, 0);
    @(negedge clk);
    exp_perr[0] = model_perr(12'hC0C);
    valid_a = 1'b0;
    body("t2b", 0, 12'hC0C, 0);
    idle_cycle("t2.after", 0);

    // Valid during an active frame is ignored; exactly one DONE follows
    f = 12'($urandom);
    offer("t3", 0, f);
    valid_a = 1'b0;
    body("t3", 0, f, 2);
    idle_cycle("t3.after", 0);
    idle_cycle("t3.after2", 0);

    // Reset in the middle of bit 7
    f = 12'($urandom);
    offer("t4", 0, f);
    valid_a = 1'b0;
    for (int k = 0; k < 4 * 4 + 2; k++) begin
      chk($sformatf("t4.bit%0d", 11 - k / 4), tx_a, f[11 - k / 4]);
      @(negedge clk);
    end
    rst_n = 1'b0;
    exp_perr[0] = 1'b0;
    exp_perr[1] = 1'b0;
    #1;
    chk_outs("t4.async", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_outs("t4.hold1", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_outs("t4.hold2", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle_cycle("t4.release", 0);
    f = 12'($urandom);
    offer("t4n", 0, f);
    valid_a = 1'b0;
    body("t4n", 0, f, 0);
    idle_cycle("t4n.after", 0);

    // Parity flag for a matching and a mismatching frame
    offer("t5a", 0, 12'hC0C);
    valid_a = 1'b0;
    body("t5a", 0, 12'hC0C, 0);
    offer("t5b", 0, 12'hC08);
    valid_a = 1'b0;
    body("t5b", 0, 12'hC08, 0);
    idle_cycle("t5.after", 0);

    // One clock per bit, then back-to-back on the same instance
    offer("t6", 1, 12'hAAA);
    valid_b = 1'b0;
    body("t6", 1, 12'hAAA, 0);
    f = 12'($urandom);
    offer("t6b", 1, f);
    valid_b = 1'b0;
    body("t6b", 1, f, 1);
    idle_cycle("t6.after", 1);

    // Randomized frames on either instance
    for (int n = 0; n < 10; n++) begin
      sel  = int'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 2));
      gap  = int'($urandom_range(0, 3));
      f    = 12'($urandom);
      offer($sformatf("rnd%0d", n), sel, f);
      set_valid(sel, 1'b0);
      body($sformatf("rnd%0d", n), sel, f, mode);
      for (int g = 0; g < gap; g++) begin
        idle_cycle($sformatf("rnd%0d.gap", n), sel);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
